// File: rtl/truth_table_sequencer_pkg.sv
// rtl/truth_table_sequencer_pkg.sv - shared state encodings, constants and helpers for the truth-table sequencer
package truth_table_sequencer_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Golden-function selector values for CHECK_AND
    localparam int GOLDEN_AND_OFF = 0;
    localparam int GOLDEN_AND_ON  = 1;

    // Width of the settle counter; a single bit is kept even when SETTLE is 1
    function automatic int settle_cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

    // Case-equality compare so that X/Z on either response is flagged as a failure
    function automatic logic resp_fail(input logic a, input logic b, input logic golden,
                                       input logic check_golden);
        return (a !== b) | (check_golden & (a !== golden));
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// rtl/truth_table_sequencer_if.sv - stimulus/response and result bundle between sequencer and its environment
//  start          request a sweep
//  stim           vector driven to both implementations
//  resp_a/resp_b  gate-level / expression-level outputs
//  busy/done      sweep in progress / one-cycle completion pulse
//  mismatch, err_count, first_err_vec   sweep results
interface truth_table_sequencer_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] stim;
    logic            resp_a;
    logic            resp_b;
    logic            busy;
    logic            done;
    logic            mismatch;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_vec;

    modport master (
        input  start, resp_a, resp_b,
        output stim, busy, done, mismatch, err_count, first_err_vec
    );

    modport slave (
        output start, resp_a, resp_b,
        input  stim, busy, done, mismatch, err_count, first_err_vec
    );
endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// rtl/truth_table_sequencer_settle_timer.sv - down-counter holding stim for SETTLE cycles before sampling
//  clk, rst   clock, synchronous active-high reset
//  load       load SETTLE-1
//  dec        decrement by one
//  zero       count has reached zero
module truth_table_sequencer_settle_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = settle_cnt_width(SETTLE);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - handshaked exhaustive truth-table sweep comparing two gate implementations
//  clk, rst   clock, synchronous active-high reset
//  bus        master side: start in, stim out, resp_a/resp_b in, busy/done/mismatch/err_count/first_err_vec out
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int SETTLE    = 1,
    parameter int CHECK_AND = GOLDEN_AND_ON
) (
    input  logic                          clk,
    input  logic                          rst,
    truth_table_sequencer_if.master       bus
);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    logic [1:0]      state;
    logic [N_IN-1:0] stim;
    logic            mismatch;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_vec;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero;
    logic            fail;

    truth_table_sequencer_settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    always_comb begin
        // Reload on sweep start and on every step to the next vector
        tmr_load = ((state == ST_IDLE) && bus.start) ||
                   ((state == ST_SAMPLE) && (stim != STIM_LAST));
        tmr_dec  = (state == ST_WAIT) && !tmr_zero;
        fail     = resp_fail(bus.resp_a, bus.resp_b, &stim, CHECK_AND != GOLDEN_AND_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            stim          <= '0;
            mismatch      <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state         <= ST_WAIT;
                        stim          <= '0;
                        mismatch      <= 1'b0;
                        err_count     <= '0;
                        first_err_vec <= '0;
                    end
                end
                ST_WAIT: begin
                    if (tmr_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (fail) begin
                        // At most 2**N_IN failures fit in N_IN+1 bits, so no saturation needed
                        err_count <= err_count + (N_IN+1)'(1);
                        mismatch  <= 1'b1;
                        if (!mismatch) begin
                            first_err_vec <= stim;
                        end
                    end
                    // All-ones is terminal so stim never wraps within a sweep
                    if (stim == STIM_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        stim  <= stim + N_IN'(1);
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stim          = stim;
    assign bus.busy          = (state == ST_WAIT) || (state == ST_SAMPLE);
    assign bus.done          = (state == ST_DONE);
    assign bus.mismatch      = mismatch;
    assign bus.err_count     = err_count;
    assign bus.first_err_vec = first_err_vec;
endmodule
